// File: rtl/instr_fetch_unit_pkg.sv
// Shared KGP-RISC definitions: opcodes, instr_select encodings, instruction
// field positions and the fetch sequencer state type.
package kgp_risc_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b001110;
  localparam logic [5:0] OP_BLTZ = 6'b010011;
  localparam logic [5:0] OP_BZ   = 6'b010100;
  localparam logic [5:0] OP_BNZ  = 6'b010101;
  localparam logic [5:0] OP_B    = 6'b100000;
  localparam logic [5:0] OP_BL   = 6'b100001;
  localparam logic [5:0] OP_BCY  = 6'b100010;
  localparam logic [5:0] OP_BNCY = 6'b100011;

  localparam logic [1:0] SEL_PC1   = 2'b00;
  localparam logic [1:0] SEL_IMM   = 2'b01;
  localparam logic [1:0] SEL_LABEL = 2'b10;
  localparam logic [1:0] SEL_REG   = 2'b11;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int LABEL_MSB = 25;
  localparam int LABEL_LSB = 0;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_MEM   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/valid bus between the fetch unit (master) and
// instruction memory (slave).
interface instr_fetch_unit_if #(
  parameter int PC_W = 32
) ();
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_branch_resolver.sv
// Combinational next-PC selection: sequential, conditional immediate branch,
// label branch or register branch, all modulo 2^PC_W.
module branch_resolver
  import kgp_risc_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [5:0]      opcode,
  input  logic [1:0]      instr_select,
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  input  logic [25:0]     label,
  input  logic [31:0]     rs_data,
  input  logic            carry_flag,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] imm_off;
  logic [PC_W-1:0] label_off;
  logic            taken;

  assign seq_pc    = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign imm_off   = {{(PC_W-16){imm[15]}}, imm};
  assign label_off = {{(PC_W-26){label[25]}}, label};

  // Branch condition; an opcode that does not match its select is never taken
  always_comb begin
    taken = 1'b0;
    case (instr_select)
      SEL_IMM: begin
        case (opcode)
          OP_BLTZ: taken = rs_data[31];
          OP_BZ:   taken = (rs_data == 32'h0000_0000);
          OP_BNZ:  taken = (rs_data != 32'h0000_0000);
          default: taken = 1'b0;
        endcase
      end
      SEL_LABEL: begin
        case (opcode)
          OP_B, OP_BL: taken = 1'b1;
          OP_BCY:      taken = carry_flag;
          OP_BNCY:     taken = ~carry_flag;
          default:     taken = 1'b0;
        endcase
      end
      default: taken = 1'b0;
    endcase
  end

  // Target selection
  always_comb begin
    next_pc = seq_pc;
    case (instr_select)
      SEL_PC1:   next_pc = seq_pc;
      SEL_IMM:   if (taken) next_pc = seq_pc + imm_off;   else next_pc = seq_pc;
      SEL_LABEL: if (taken) next_pc = seq_pc + label_off; else next_pc = seq_pc;
      SEL_REG:   next_pc = rs_data[PC_W-1:0];
      default:   next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// KGP-RISC multi-cycle fetch/PC sequencer: FETCH -> WAIT -> EXEC [-> MEM],
// holding the instruction register and retiring one instruction per pass.
module instr_fetch_unit
  import kgp_risc_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  output logic [5:0]          opcode,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [15:0]         imm,
  output logic [25:0]         label,
  output logic                instr_valid,
  input  logic [1:0]          instr_select,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [31:0]         rs_data,
  input  logic                carry_flag,
  input  logic                dmem_done,
  output logic [PC_W-1:0]     pc,
  output logic [PC_W-1:0]     pc_plus1,
  output logic                commit
);

  fetch_state_e    state;
  logic [31:0]     ir;
  logic            fetch_req;
  logic [PC_W-1:0] next_pc;

  assign opcode   = ir[OPC_MSB:OPC_LSB];
  assign rs       = ir[RS_MSB:RS_LSB];
  assign rt       = ir[RT_MSB:RT_LSB];
  assign imm      = ir[IMM_MSB:IMM_LSB];
  assign label    = ir[LABEL_MSB:LABEL_LSB];
  assign pc_plus1 = pc + {{(PC_W-1){1'b0}}, 1'b1};

  assign imem.imem_req  = fetch_req;
  assign imem.imem_addr = pc;

  branch_resolver #(.PC_W(PC_W)) u_branch_resolver (
    .opcode       (opcode),
    .instr_select (instr_select),
    .pc           (pc),
    .imm          (imm),
    .label        (label),
    .rs_data      (rs_data),
    .carry_flag   (carry_flag),
    .next_pc      (next_pc)
  );

  // Retire pulse follows the control unit's same-cycle decode; a reset cycle never retires
  always_comb begin
    commit = 1'b0;
    if (rst) begin
      commit = 1'b0;
    end else if (state == S_EXEC) begin
      commit = ~(mem_read | mem_write);
    end else if (state == S_MEM) begin
      commit = dmem_done;
    end else begin
      commit = 1'b0;
    end
  end

  // Sequencer; fetch_req is raised on entry to FETCH so the request lasts exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      ir          <= 32'h0000_0000;
      fetch_req   <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (fetch_req) begin
            fetch_req <= 1'b0;
            state     <= S_WAIT;
          end else begin
            fetch_req <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem.imem_valid) begin
            ir          <= imem.imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (mem_read | mem_write) begin
            state <= S_MEM;
          end else begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            fetch_req   <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_done) begin
            pc          <= pc_plus1;
            instr_valid <= 1'b0;
            fetch_req   <= 1'b1;
            state       <= S_FETCH;
          end
        end
        default: begin
          state       <= S_FETCH;
          fetch_req   <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: the bench plays instruction memory
// and control unit, and predicts the PC sequence from the ISA branch rules.
module tb_instr_fetch_unit;

  localparam logic [5:0] T_ADD  = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b001110;
  localparam logic [5:0] T_BLTZ = 6'b010011;
  localparam logic [5:0] T_BZ   = 6'b010100;
  localparam logic [5:0] T_BNZ  = 6'b010101;
  localparam logic [5:0] T_B    = 6'b100000;
  localparam logic [5:0] T_BL   = 6'b100001;
  localparam logic [5:0] T_BCY  = 6'b100010;
  localparam logic [5:0] T_BNCY = 6'b100011;
  localparam logic [5:0] T_NOP  = 6'b111111;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic [25:0] label;
  logic        instr_valid;
  logic [1:0]  instr_select;
  logic        mem_read, mem_write;
  logic [31:0] rs_data;
  logic        carry_flag, dmem_done;
  logic [31:0] pc, pc_plus1;
  logic        commit;

  int total, bad, cyc;
  logic [31:0] model_pc;

  bit          obs_timeout, obs_iv_ok;
  int          obs_req_cycles, obs_commits, obs_commit_rel, obs_commit_cyc;
  logic [31:0] obs_addr, obs_commit_pc, obs_commit_p1, obs_pc_after, obs_fields;
  logic [25:0] obs_label;

  instr_fetch_unit_if #(.PC_W(32)) imem ();

  instr_fetch_unit #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem(imem),
    .opcode(opcode), .rs(rs), .rt(rt), .imm(imm), .label(label),
    .instr_valid(instr_valid), .instr_select(instr_select),
    .mem_read(mem_read), .mem_write(mem_write), .rs_data(rs_data),
    .carry_flag(carry_flag), .dmem_done(dmem_done),
    .pc(pc), .pc_plus1(pc_plus1), .commit(commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ISA-level next-PC: plain signed arithmetic modulo 2^32
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] instr,
                                           input logic [1:0] sel, input logic mem,
                                           input logic [31:0] rsd, input logic cy);
    longint p1, off;
    bit taken;
    logic [5:0] op;
    op = instr[31:26];
    p1 = longint'(cur) + 64'sd1;
    off = 64'sd0;
    taken = 1'b0;
    if (mem) return 32'(p1);
    case (sel)
      2'd1: begin
        taken = (op == T_BLTZ && rsd[31]) || (op == T_BZ && rsd == 32'd0) || (op == T_BNZ && rsd != 32'd0);
        off = longint'($signed(instr[15:0]));
      end
      2'd2: begin
        taken = (op inside {T_B, T_BL}) || (op == T_BCY && cy) || (op == T_BNCY && !cy);
        off = longint'($signed(instr[25:0]));
      end
      2'd3: return rsd;
      default: taken = 1'b0;
    endcase
    return taken ? 32'(p1 + off) : 32'(p1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_cycle(input int idx, input bit exp_iv);
    if (imem.imem_req === 1'b1) obs_req_cycles++;
    if (commit === 1'b1) begin
      obs_commits++;
      obs_commit_rel = idx;
      obs_commit_cyc = cyc;
      obs_commit_pc  = pc;
      obs_commit_p1  = pc_plus1;
    end
    if (instr_valid !== exp_iv) obs_iv_ok = 1'b0;
  endtask

  // Serves one fetch with the given latency and plays the control unit for it.
  // Cycle index 0 is the request cycle; returns in the next FETCH cycle.
  task automatic drive_instr(input logic [31:0] instr, input logic [1:0] sel,
                             input logic mr, input logic mw, input logic [31:0] rsd,
                             input logic cy, input int lat, input int mc);
    int n, idx;
    obs_timeout = 1'b0; obs_iv_ok = 1'b1; obs_req_cycles = 0; obs_commits = 0;
    obs_commit_rel = -1; obs_commit_cyc = 0;
    n = 0;
    while (imem.imem_req !== 1'b1 && n < 20) begin tick(); n++; end
    if (imem.imem_req !== 1'b1) begin obs_timeout = 1'b1; return; end
    obs_addr = imem.imem_addr;
    idx = 0;
    sample_cycle(idx, 1'b0);
    for (int i = 1; i <= lat; i++) begin
      tick(); idx++;
      imem.imem_valid = (i == lat);
      imem.imem_rdata = (i == lat) ? instr : $urandom;
      dmem_done = 1'($urandom);
      #1;
      sample_cycle(idx, 1'b0);
    end
    tick(); idx++;
    imem.imem_valid = 1'b0; imem.imem_rdata = $urandom; dmem_done = 1'b0;
    instr_select = sel; mem_read = mr; mem_write = mw; rs_data = rsd; carry_flag = cy;
    #1;
    obs_fields = {opcode, rs, rt, imm};
    obs_label  = label;
    sample_cycle(idx, 1'b1);
    if (mr | mw) begin
      for (int m = 0; m <= mc; m++) begin
        tick(); idx++;
        dmem_done = (m == mc);
        #1;
        sample_cycle(idx, 1'b1);
      end
    end
    tick();
    instr_select = 2'b00; mem_read = 1'b0; mem_write = 1'b0; dmem_done = 1'b0;
    #1;
    obs_pc_after = pc;
    if (instr_valid !== 1'b0) obs_iv_ok = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    drive_instr({T_NOP, 26'($urandom)}, 2'b11, 1'b0, 1'b0, target, 1'b0, 1, 0);
    model_pc = target;
  endtask

  task automatic run_nop();
    drive_instr({T_NOP, 26'($urandom)}, 2'b00, 1'b0, 1'b0, $urandom, 1'($urandom), 1, 0);
    model_pc = model_pc + 32'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dmem_done = 1'b1;
    repeat (3) tick();
    total++;
    if (pc !== 32'd0 || imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || commit !== 1'b0) begin
      $display("FAIL reset_ctrl got pc=%h req=%b iv=%b commit=%b exp pc=0 req=0 iv=0 commit=0", pc, imem.imem_req, instr_valid, commit); bad++;
    end
    total++;
    if ({opcode, rs, rt, imm} !== 32'd0 || label !== 26'd0) begin
      $display("FAIL reset_fields got %h/%h exp 0", {opcode, rs, rt, imm}, label); bad++;
    end
    rst = 1'b0; dmem_done = 1'b0;
    #1;
    total++;
    if (imem.imem_req !== 1'b0) begin $display("FAIL reset_release_req got=%b exp=0", imem.imem_req); bad++; end
    tick();
    total++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'd0) begin
      $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem.imem_req, imem.imem_addr); bad++;
    end
    model_pc = 32'd0;
  endtask

  task automatic test_adds();
    int prev_cyc;
    prev_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      drive_instr({T_ADD, 26'($urandom)}, 2'b00, 1'b0, 1'b0, $urandom, 1'($urandom), 1, 0);
      total++;
      if (obs_timeout || obs_addr !== model_pc) begin $display("FAIL add_addr k=%0d got=%h exp=%h", k, obs_addr, model_pc); bad++; end
      total++;
      if (obs_commits !== 1 || obs_commit_rel !== 2) begin
        $display("FAIL add_commit k=%0d got commits=%0d at=%0d exp 1 at 2", k, obs_commits, obs_commit_rel); bad++;
      end
      if (k > 0) begin
        total++;
        if (obs_commit_cyc - prev_cyc !== 3) begin $display("FAIL add_spacing got=%0d exp=3", obs_commit_cyc - prev_cyc); bad++; end
      end
      prev_cyc = obs_commit_cyc;
      model_pc = model_pc + 32'd1;
    end
    total++;
    if (pc !== model_pc) begin $display("FAIL add_pc got=%h exp=%h", pc, model_pc); bad++; end
  endtask

  task automatic test_fetch_latency();
    logic [31:0] instr;
    for (int g = 0; g < 8 && model_pc != 32'd5; g++) run_nop();
    instr = {T_ADD, 26'($urandom)};
    drive_instr(instr, 2'b00, 1'b0, 1'b0, $urandom, 1'b0, 4, 0);
    total++;
    if (obs_timeout || obs_addr !== 32'd5 || obs_req_cycles !== 1) begin
      $display("FAIL lat4_req got addr=%h reqs=%0d exp addr=5 reqs=1", obs_addr, obs_req_cycles); bad++;
    end
    total++;
    if (obs_commit_rel !== 5 || obs_commits !== 1) begin $display("FAIL lat4_exec got at=%0d exp=5", obs_commit_rel); bad++; end
    total++;
    if (obs_fields !== instr || obs_label !== instr[25:0] || !obs_iv_ok) begin
      $display("FAIL lat4_ir got=%h exp=%h iv_ok=%b", obs_fields, instr, obs_iv_ok); bad++;
    end
    model_pc = 32'd6;
    total++;
    if (obs_pc_after !== model_pc) begin $display("FAIL lat4_pc got=%h exp=%h", obs_pc_after, model_pc); bad++; end
  endtask

  task automatic test_cond_branch();
    logic [5:0]  ops [6]  = '{T_BZ, T_BZ, T_BLTZ, T_BLTZ, T_BNZ, T_BNZ};
    logic [31:0] rsv [6]  = '{32'd0, 32'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd5};
    logic [31:0] fixed [2] = '{32'd9, 32'd11};
    logic [31:0] instr, exp;
    for (int i = 0; i < 6; i++) begin
      goto_pc(32'd10);
      instr = (i < 2) ? {ops[i], 5'd1, 5'd2, 16'hFFFE} : {ops[i], 10'($urandom), 16'($urandom)};
      drive_instr(instr, 2'b01, 1'b0, 1'b0, rsv[i], 1'($urandom), 1, 0);
      exp = ref_next(model_pc, instr, 2'b01, 1'b0, rsv[i], 1'b0);
      if (i < 2) exp = fixed[i];
      total++;
      if (obs_timeout || obs_addr !== 32'd10 || obs_pc_after !== exp) begin
        $display("FAIL cond_branch i=%0d op=%b rs=%h got pc=%h exp=%h", i, ops[i], rsv[i], obs_pc_after, exp); bad++;
      end
      model_pc = exp;
    end
  endtask

  task automatic test_label_branch();
    logic [5:0]  ops [5] = '{T_BCY, T_BCY, T_BNCY, T_BNCY, T_B};
    logic        cys [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] instr, exp;
    drive_instr({T_NOP, 26'($urandom)}, 2'b11, 1'b0, 1'b0, 32'h40, 1'b0, 1, 0);
    model_pc = 32'h40;
    run_nop();
    total++;
    if (obs_addr !== 32'h40) begin $display("FAIL br_fetch got=%h exp=40", obs_addr); bad++; end
    goto_pc(32'd20);
    drive_instr({T_BL, 26'd5}, 2'b10, 1'b0, 1'b0, $urandom, 1'b0, 1, 0);
    total++;
    if (obs_pc_after !== 32'd26 || obs_commit_pc !== 32'd20 || obs_commit_p1 !== 32'd21) begin
      $display("FAIL bl got pc=%h cpc=%h link=%h exp 1a/14/15", obs_pc_after, obs_commit_pc, obs_commit_p1); bad++;
    end
    for (int i = 0; i < 5; i++) begin
      goto_pc(32'd20);
      instr = {ops[i], (i == 4) ? 26'h3FF_FFF0 : 26'($urandom_range(1, 200))};
      drive_instr(instr, 2'b10, 1'b0, 1'b0, $urandom, cys[i], 2, 0);
      exp = ref_next(model_pc, instr, 2'b10, 1'b0, 32'd0, cys[i]);
      if (i == 0) exp = 32'd21;
      total++;
      if (obs_pc_after !== exp) begin $display("FAIL label_branch i=%0d got=%h exp=%h", i, obs_pc_after, exp); bad++; end
      model_pc = exp;
    end
    goto_pc(32'hFFFF_FFFF);
    run_nop();
    total++;
    if (obs_pc_after !== 32'd0) begin $display("FAIL pc_wrap got=%h exp=0", obs_pc_after); bad++; end
  endtask

  task automatic test_mem();
    goto_pc(32'h100);
    drive_instr({T_LW, 26'($urandom)}, 2'b00, 1'b1, 1'b0, $urandom, 1'b0, 1, 3);
    total++;
    if (!obs_iv_ok || obs_commits !== 1 || obs_commit_rel !== 6) begin
      $display("FAIL lw_commit got iv_ok=%b commits=%0d at=%0d exp 1/1/6", obs_iv_ok, obs_commits, obs_commit_rel); bad++;
    end
    total++;
    if (obs_pc_after !== 32'h101 || obs_commit_pc !== 32'h100) begin
      $display("FAIL lw_pc got=%h exp=101", obs_pc_after); bad++;
    end
    model_pc = 32'h101;
    drive_instr({6'b001111, 26'($urandom)}, 2'b11, 1'b0, 1'b1, 32'h5555, 1'b0, 1, 0);
    total++;
    if (obs_commits !== 1 || obs_commit_rel !== 3 || obs_pc_after !== 32'h102) begin
      $display("FAIL sw_fast got commits=%0d at=%0d pc=%h exp 1/3/102", obs_commits, obs_commit_rel, obs_pc_after); bad++;
    end
    model_pc = 32'h102;
  endtask

  task automatic test_rst_mid();
    logic [31:0] instr;
    goto_pc(32'h123);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (pc !== 32'd0 || imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || commit !== 1'b0 || opcode !== 6'd0) begin
      $display("FAIL rst_wait got pc=%h req=%b iv=%b commit=%b exp reset values", pc, imem.imem_req, instr_valid, commit); bad++;
    end
    model_pc = 32'd0;
    imem.imem_valid = 1'b1; imem.imem_rdata = 32'hFFFF_FFFF;
    tick();
    instr = {T_ADD, 26'($urandom)};
    drive_instr(instr, 2'b00, 1'b0, 1'b0, $urandom, 1'b0, 2, 0);
    total++;
    if (obs_timeout || obs_addr !== 32'd0 || obs_fields !== instr || obs_commits !== 1 || obs_pc_after !== 32'd1) begin
      $display("FAIL late_valid got addr=%h ir=%h pc=%h exp 0/%h/1", obs_addr, obs_fields, obs_pc_after, instr); bad++;
    end
    tick();
    imem.imem_valid = 1'b1; imem.imem_rdata = {T_LW, 26'd0};
    tick();
    imem.imem_valid = 1'b0; mem_read = 1'b1;
    tick();
    dmem_done = 1'b0;
    tick();
    rst = 1'b1; dmem_done = 1'b1;
    #1;
    total++;
    if (commit !== 1'b0 || instr_valid !== 1'b1) begin $display("FAIL rst_mem_commit got commit=%b iv=%b exp 0/1", commit, instr_valid); bad++; end
    tick();
    rst = 1'b0; dmem_done = 1'b0; mem_read = 1'b0;
    #1;
    total++;
    if (pc !== 32'd0 || instr_valid !== 1'b0 || imem.imem_req !== 1'b0 || commit !== 1'b0) begin
      $display("FAIL rst_mem got pc=%h iv=%b req=%b commit=%b exp reset values", pc, instr_valid, imem.imem_req, commit); bad++;
    end
    model_pc = 32'd0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [5:0]  op;
      logic [31:0] instr, rsd, exp;
      logic [1:0]  sel;
      logic        mr, mw, cy;
      int          lat, mc, exp_rel;
      case ($urandom_range(0, 9))
        0: op = T_ADD;  1: op = T_LW;  2: op = T_BLTZ; 3: op = T_BZ;  4: op = T_BNZ;
        5: op = T_B;    6: op = T_BL;  7: op = T_BCY;  8: op = T_BNCY;
        default: op = 6'($urandom);
      endcase
      instr = {op, 26'($urandom)};
      sel = 2'($urandom);
      if ($urandom_range(0, 3) != 0)
        sel = (op inside {T_BLTZ, T_BZ, T_BNZ}) ? 2'b01 : (op inside {T_B, T_BL, T_BCY, T_BNCY}) ? 2'b10 : 2'b00;
      mr = (op == T_LW);
      mw = !mr && ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: rsd = 32'd0;
        1: rsd = 32'h8000_0000 | $urandom;
        default: rsd = $urandom;
      endcase
      cy = 1'($urandom);
      lat = $urandom_range(1, 3);
      mc = $urandom_range(0, 2);
      drive_instr(instr, sel, mr, mw, rsd, cy, lat, mc);
      exp = ref_next(model_pc, instr, sel, mr | mw, rsd, cy);
      exp_rel = lat + 1 + ((mr | mw) ? mc + 1 : 0);
      total++;
      if (obs_timeout || obs_addr !== model_pc || obs_pc_after !== exp) begin
        $display("FAIL rand_pc it=%0d instr=%h sel=%b rs=%h got addr=%h next=%h exp addr=%h next=%h",
                 it, instr, sel, rsd, obs_addr, obs_pc_after, model_pc, exp); bad++;
      end
      total++;
      if (obs_commits !== 1 || obs_commit_rel !== exp_rel || !obs_iv_ok || obs_req_cycles !== 1 || obs_fields !== instr) begin
        $display("FAIL rand_seq it=%0d got commits=%0d at=%0d iv_ok=%b reqs=%0d ir=%h exp 1/%0d/1/1/%h",
                 it, obs_commits, obs_commit_rel, obs_iv_ok, obs_req_cycles, obs_fields, exp_rel, instr); bad++;
      end
      model_pc = exp;
    end
  endtask

  initial begin
    total = 0; bad = 0; model_pc = 32'd0;
    rst = 1'b1; instr_select = 2'b00; mem_read = 1'b0; mem_write = 1'b0;
    rs_data = 32'd0; carry_flag = 1'b0; dmem_done = 1'b0;
    imem.imem_valid = 1'b0; imem.imem_rdata = 32'd0;
    test_reset();
    test_adds();
    test_fetch_latency();
    test_cond_branch();
    test_label_branch();
    test_mem();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and PC sequencing unit for KGP-RISC. It sits upstream of the control unit. It fetches 32-bit instructions from instruction memory over a request/valid handshake, holds them in an instruction register, and presents the opcode and fields to the control unit. It then consumes the control unit's `instr_select`, `mem_read` and `mem_write` outputs, plus the register and flag state, to resolve branches and advance the PC one instruction at a time (multi-cycle, non-pipelined).

## Interface
- `PC_W`, 32, PC and instruction-memory address width (word-addressed)
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  one-cycle fetch request
- `imem_addr`  out  PC_W  fetch address, equals `pc`
- `imem_valid`  in  1  `imem_rdata` valid
- `imem_rdata`  in  32  fetched instruction
- `opcode`  out  6  ir[31:26], to control unit
- `rs`, `rt`  out  5 each  ir[25:21], ir[20:16]
- `imm`  out  16  ir[15:0]
- `label`  out  26  ir[25:0]
- `instr_valid`  out  1  ir holds an instruction under execution
- `instr_select`  in  2  from control unit: 00 pc+1, 01 conditional imm branch, 10 label branch, 11 register branch
- `mem_read`, `mem_write`  in  1 each  from control unit
- `rs_data`  in  32  register-file read of rs
- `carry_flag`  in  1  ALU carry flag
- `dmem_done`  in  1  data-memory access complete
- `pc`  out  PC_W  address of the current instruction
- `pc_plus1`  out  PC_W  pc+1, link value for bl
- `commit`  out  1  one-cycle retire pulse; gates register/flag writes

## Operation
- States: FETCH, WAIT, EXEC, MEM.
- FETCH: `imem_req`=1, `imem_addr`=pc. Always go to WAIT next cycle.
- WAIT: when `imem_valid`=1, load ir ← `imem_rdata` and go to EXEC; otherwise stay in WAIT. `imem_valid` is ignored in every other state.
- EXEC: `instr_valid`=1. Sample `instr_select`, `rs_data`, `carry_flag`.
  - If `mem_read|mem_write`: go to MEM.
  - Otherwise: `commit`=1, pc ← next_pc, go to FETCH.
- MEM: `instr_valid`=1. On `dmem_done`: `commit`=1, pc ← pc+1, go to FETCH. Otherwise hold.
- next_pc by `instr_select`:
  - 00 → pc+1
  - 01 → pc+1+sext(imm) if taken, else pc+1. Taken when: bltz (opcode 010011) rs_data[31]=1; bz (010100) rs_data==0; bnz (010101) rs_data!=0.
  - 10 → pc+1+sext(label) if taken, else pc+1. b (100000) and bl (100001) always taken; bcy (100010) when carry=1; bncy (100011) when carry=0.
  - 11 → rs_data[PC_W-1:0] (br).
  - Any other opcode combined with a branch select → pc+1.
- Arithmetic is modulo 2^PC_W. PC wraps from all-ones to 0 with no error.
- Unlisted opcodes execute as NOP: commit, pc+1.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, ir=0, `imem_req`=0, `instr_valid`=0, `commit`=0. Field outputs are 0.
- First `imem_req` occurs the cycle after `rst` deasserts.
- `rst` overrides every state, including mid-WAIT and mid-MEM. Instruction memory shares `rst` and discards outstanding requests.
- Minimum instruction time: non-memory instruction 3 cycles (FETCH, WAIT with `imem_valid` on its first cycle, EXEC); memory instruction 4 cycles.
- The `imem_valid` wait is unbounded. A response must not arrive in the same cycle as its `imem_req`.
- Field outputs remain stable from WAIT→EXEC until the next ir load.
- `dmem_done` in the MEM entry cycle is honoured. `dmem_done` outside MEM is ignored.
- `commit` is never high in two consecutive cycles.

## Structure
- Shared package `kgp_risc_pkg` holds:
  - opcode localparams (OP_ADD … OP_BNCY)
  - instr_select encodings (SEL_PC1, SEL_IMM, SEL_LABEL, SEL_REG)
  - instruction field bit positions
- The control unit also imports `kgp_risc_pkg`.
- One combinational sub-module, `branch_resolver`: inputs opcode, instr_select, pc, imm, label, rs_data, carry_flag; output next_pc. The state machine and registers stay in the top.

## Test plan
- Reset then three add (opcode 0) instructions, `imem_valid` latency 1 → `imem_addr` 0,1,2; `commit` every 3rd cycle; pc=3.
- Fetch latency 4 at pc=5 → `imem_req` single-cycle; EXEC begins the cycle after `imem_valid`; ir equals `imem_rdata`.
- bz at pc=10, imm=0xFFFE: rs_data=0 → pc=9; rs_data=7 → pc=11. bltz with rs_data=0x80000000 → taken.
- br, rs_data=0x40 → next fetch at 0x40. bl at pc=20, label=5 → pc=26, `pc_plus1`=21 at `commit`. bcy with carry=0 → pc=21.
- lw (001110) with `dmem_done` after 3 MEM cycles → `instr_valid` high through MEM; single `commit` on the done cycle; pc+1.
- `rst` asserted in WAIT and again in MEM → next cycle pc=RESET_PC, all outputs at reset values, no `commit`; late `imem_valid` in FETCH ignored.
